booth_radix8_mult: RTL and testbench
====================================

Name: booth_radix8_mult

Overview:
- Parametrised, self-contained sequential radix-8 Booth multiplier with integrated control FSM and datapath.
- Successor to the fixed 15-bit split control/data_path multiplier.
- Generalised to WIDTH-bit operands, with a signed/unsigned mode, start/busy/done handshake, registered full-width product, and zero-operand early termination.
- Sits as a multiply engine behind a simple request/complete handshake.

Parameters:
- WIDTH, 15, operand width in bits (legal range 4..32).
- NDIG, ceil((WIDTH+1)/3), derived localparam: number of radix-8 digits/iterations; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- tc  in  1  1 = operands are two's complement, 0 = unsigned; captured with start.
- multiplicand  in  WIDTH  operand M; captured with start.
- multiplier  in  WIDTH  operand Q; captured with start.
- busy  out  1  high from the accepting edge through the done cycle inclusive.
- done  out  1  single-cycle pulse; product valid.
- product  out  2*WIDTH  result; held until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, product=0; iteration counter and accumulator cleared. Reset asserted mid-operation aborts immediately. No done is produced for the aborted job.
- Operands are extended internally to WIDTH+1 bits: sign-extended if tc=1, zero-extended if tc=0. This lets one datapath serve both modes.
- Accumulator is sized WIDTH+4 bits, so digit*M for digit in -4..+4 never overflows.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1 at edge 0, either operand zero: go to DONE; product<=0; busy<=1.
- IDLE, start=1 at edge 0, otherwise:
  - Capture operands and tc.
  - Register 3M = M + 2M.
  - Clear accumulator A and Q[-1].
  - Set count=0; go to CALC; busy<=1.
- CALC, each cycle:
  - Recode the 4-bit window {Q[2:0],Q[-1]} to digit d: 0000/1111=0, 0001/0010=+1, 0011/0100=+2, 0101/0110=+3, 0111=+4, 1000=-4, 1001/1010=-3, 1011/1100=-2, 1101/1110=-1.
  - A <= A + d*M, using M, 2M, 3M or 4M and their negations.
  - Arithmetic shift {A,Q,Q-1} right by 3.
  - count <= count+1.
  - After NDIG iterations, go to DONE and load product from the low 2*WIDTH bits of {A,Q}.
- DONE, one cycle: done=1, busy=1; next state IDLE, busy<=0.
- Latency: done is high in the cycle after edge NDIG+1 (normal case) or after edge 1 (zero operand). For WIDTH=15, NDIG=6, so latency is 7 cycles.
- start while busy=1 (including the DONE cycle) is ignored; it has no effect on the running job. Back-to-back jobs need start held or re-asserted in IDLE.
- product changes only on entry to DONE; it is stable at all other times.
- tc=0 with the MSB set: the operand is treated as a positive value up to 2^WIDTH-1; the unsigned product is exact in 2*WIDTH bits.
- tc=1: the product is the exact signed result in 2*WIDTH bits, including (-2^(WIDTH-1))^2.

Test Plan:
1. WIDTH=15, tc=1, M=4, Q=5, single start pulse -> busy high for 7 cycles; done pulses once in cycle 7; product=20.
2. tc=1, M=-7, Q=3 -> product=-21 (30'h3FFFFFEB). Then tc=1, M=-16384, Q=-16384 -> product=268435456.
3. tc=0, M=Q=32767; then tc=0, M=0x7FFF, Q=0x4000 -> products 1073676289 and 536854528. Repeat with WIDTH=8, tc=0, M=Q=255 -> product=65025.
4. Zero operand: M=0, Q=1234 (and M=99, Q=0) -> done after 1 cycle; product=0; busy high for exactly 1 cycle.
5. start held high throughout with alternating operand sets -> each job completes with the correct product. Operand and start changes during busy do not disturb results; the next job is accepted only in IDLE.
6. Assert rst low at CALC iteration 3 of M=4, Q=5 -> busy, done and product go to 0 immediately with no done pulse. After release, a new job M=6, Q=-2 gives -12.

Source files
------------

// File: rtl/booth_radix8_mult_if.sv
// Request/complete handshake bundle for the radix-8 Booth multiplier.
// master drives the request side, slave is the multiply engine.
interface booth_radix8_mult_if #(
  parameter int unsigned WIDTH = 15
);
  logic                 start;
  logic                 tc;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, tc, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, tc, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_radix8_mult.sv
// Sequential radix-8 Booth multiplier: one 3-bit digit per cycle, signed or unsigned
// operands, zero-operand early exit, registered full-width product.
module booth_radix8_mult #(
  parameter int unsigned WIDTH = 15
) (
  input  logic               clk,
  input  logic               rst,
  booth_radix8_mult_if.slave mul
);

  localparam int unsigned NDIG = (WIDTH + 3) / 3;
  localparam int unsigned W1   = WIDTH + 1;
  localparam int unsigned AW   = WIDTH + 4;
  localparam int unsigned QW   = 3 * NDIG;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [W1-1:0]   m_q, m_d;
  logic [AW-1:0]   m3_q, m3_d;
  logic [AW-1:0]   a_q, a_d;
  logic [QW-1:0]   q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;

  // Operands widened by one bit so a single signed datapath covers both modes.
  logic [W1-1:0]   m_in, q_in;
  logic [AW-1:0]   m_in_ext, m3_in;
  logic [AW-1:0]   m_ext, addend, sum;
  logic [AW-1:0]   a_sh;
  logic [QW-1:0]   q_sh;
  logic            accept, zero_op, last_iter;

  assign m_in      = {mul.tc & mul.multiplicand[WIDTH-1], mul.multiplicand};
  assign q_in      = {mul.tc & mul.multiplier[WIDTH-1], mul.multiplier};
  assign m_in_ext  = AW'($signed(m_in));
  assign m3_in     = m_in_ext + (m_in_ext << 1);
  assign m_ext     = AW'($signed(m_q));
  assign accept    = mul.start && (state_q == StIdle);
  assign zero_op   = (mul.multiplicand == '0) || (mul.multiplier == '0);
  assign last_iter = (cnt_q == CW'(NDIG - 1));

  // Booth recode of {Q[2:0],Q[-1]} into a digit in -4..+4.
  always_comb begin
    addend = '0;
    unique case ({q_q[2:0], qm1_q})
      4'b0000, 4'b1111: addend = '0;
      4'b0001, 4'b0010: addend = m_ext;
      4'b0011, 4'b0100: addend = m_ext << 1;
      4'b0101, 4'b0110: addend = m3_q;
      4'b0111:          addend = m_ext << 2;
      4'b1000:          addend = -(m_ext << 2);
      4'b1001, 4'b1010: addend = -m3_q;
      4'b1011, 4'b1100: addend = -(m_ext << 1);
      4'b1101, 4'b1110: addend = -m_ext;
      default:          addend = '0;
    endcase
  end

  assign sum  = a_q + addend;
  assign a_sh = {{3{sum[AW-1]}}, sum[AW-1:3]};
  assign q_sh = {sum[2:0], q_q[QW-1:3]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    m3_d    = m3_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (zero_op) begin
            prod_d  = '0;
            state_d = StDone;
          end else begin
            m_d     = m_in;
            m3_d    = m3_in;
            a_d     = '0;
            q_d     = QW'($signed(q_in));
            qm1_d   = 1'b0;
            cnt_d   = '0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[2];
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          prod_d  = PW'({a_sh, q_sh});
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      m3_q    <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      m3_q    <= m3_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign mul.busy    = (state_q != StIdle);
  assign mul.done    = (state_q == StDone);
  assign mul.product = prod_q;

endmodule

// File: tb/tb_booth_radix8_mult.sv
// Directed bench for booth_radix8_mult at WIDTH=15 and WIDTH=8.
module tb_booth_radix8_mult;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  booth_radix8_mult_if #(.WIDTH(15)) if15 ();
  booth_radix8_mult_if #(.WIDTH(8))  if8 ();

  booth_radix8_mult #(.WIDTH(15)) u_dut15 (
    .clk (clk),
    .rst (rst),
    .mul (if15)
  );

  booth_radix8_mult #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .mul (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one job on the 15-bit DUT, scrambles operands once accepted, and reports
  // the product seen with done, the busy length and the number of done cycles.
  task automatic run15(input logic tcv, input logic [14:0] m, input logic [14:0] q,
                       output logic [29:0] p, output int lat, output int ndone);
    @(negedge clk);
    if15.start = 1'b1;
    if15.tc = tcv;
    if15.multiplicand = m;
    if15.multiplier = q;
    @(negedge clk);
    if15.start = 1'b0;
    if15.tc = ~tcv;
    if15.multiplicand = ~m;
    if15.multiplier = q ^ 15'h1234;
    lat = 0;
    ndone = 0;
    p = 'x;
    for (int i = 0; i < 40 && if15.busy; i++) begin
      lat++;
      if (if15.done) begin
        ndone++;
        p = if15.product;
      end
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic tcv, input logic [7:0] m, input logic [7:0] q,
                      output logic [15:0] p, output int lat, output int ndone);
    @(negedge clk);
    if8.start = 1'b1;
    if8.tc = tcv;
    if8.multiplicand = m;
    if8.multiplier = q;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 0;
    ndone = 0;
    p = 'x;
    for (int i = 0; i < 40 && if8.busy; i++) begin
      lat++;
      if (if8.done) begin
        ndone++;
        p = if8.product;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (if15.busy !== 1'b0 || if15.done !== 1'b0) begin
      $display("FAIL reset_flags15: busy=%b done=%b want 0 0", if15.busy, if15.done);
      tests_failed++;
    end
    tests_run++;
    if (if15.product !== 30'h0) begin
      $display("FAIL reset_product15: got %h want 0", if15.product);
      tests_failed++;
    end
    tests_run++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.product !== 16'h0) begin
      $display("FAIL reset8: busy=%b done=%b product=%h want 0 0 0",
               if8.busy, if8.done, if8.product);
      tests_failed++;
    end
  endtask

  task automatic test_basic();
    logic [29:0] p;
    int lat, nd;
    run15(1'b1, 15'd4, 15'd5, p, lat, nd);
    tests_run++;
    if (p !== 30'd20) begin
      $display("FAIL basic_product: got %h want %h", p, 30'd20);
      tests_failed++;
    end
    tests_run++;
    if (lat !== 7) begin
      $display("FAIL basic_latency: got %0d want 7", lat);
      tests_failed++;
    end
    tests_run++;
    if (nd !== 1) begin
      $display("FAIL basic_done_count: got %0d want 1", nd);
      tests_failed++;
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (if15.product !== 30'd20 || if15.done !== 1'b0) begin
      $display("FAIL basic_hold: product=%h done=%b want %h 0", if15.product, if15.done, 30'd20);
      tests_failed++;
    end
  endtask

  task automatic test_signed();
    logic [29:0] p;
    int lat, nd;
    run15(1'b1, 15'h7FF9, 15'd3, p, lat, nd);
    tests_run++;
    if (p !== 30'h3FFFFFEB) begin
      $display("FAIL signed_neg7x3: got %h want 3fffffeb", p);
      tests_failed++;
    end
    run15(1'b1, 15'h4000, 15'h4000, p, lat, nd);
    tests_run++;
    if (p !== 30'h10000000) begin
      $display("FAIL signed_minxmin: got %h want 10000000", p);
      tests_failed++;
    end
  endtask

  task automatic test_unsigned();
    logic [29:0] p;
    logic [15:0] p8;
    int lat, nd;
    run15(1'b0, 15'h7FFF, 15'h7FFF, p, lat, nd);
    tests_run++;
    if (p !== 30'h3FFF0001) begin
      $display("FAIL unsigned_max_sq: got %h want 3fff0001", p);
      tests_failed++;
    end
    run15(1'b0, 15'h7FFF, 15'h4000, p, lat, nd);
    tests_run++;
    if (p !== 30'h1FFFC000) begin
      $display("FAIL unsigned_7fffx4000: got %h want 1fffc000", p);
      tests_failed++;
    end
    // MSB set with tc=0 must read as +16384, not -16384.
    run15(1'b0, 15'h4000, 15'd2, p, lat, nd);
    tests_run++;
    if (p !== 30'h00008000) begin
      $display("FAIL unsigned_msb: got %h want 00008000", p);
      tests_failed++;
    end
    run8(1'b0, 8'hFF, 8'hFF, p8, lat, nd);
    tests_run++;
    if (p8 !== 16'hFE01) begin
      $display("FAIL w8_unsigned_255sq: got %h want fe01", p8);
      tests_failed++;
    end
    tests_run++;
    if (lat !== 4 || nd !== 1) begin
      $display("FAIL w8_latency: got lat=%0d done=%0d want 4 1", lat, nd);
      tests_failed++;
    end
  endtask

  task automatic test_zero();
    logic [29:0] p;
    int lat, nd;
    run15(1'b1, 15'd0, 15'd1234, p, lat, nd);
    tests_run++;
    if (p !== 30'h0 || lat !== 1 || nd !== 1) begin
      $display("FAIL zero_m: got product=%h lat=%0d done=%0d want 0 1 1", p, lat, nd);
      tests_failed++;
    end
    run15(1'b1, 15'd7, 15'd9, p, lat, nd);
    run15(1'b0, 15'd99, 15'd0, p, lat, nd);
    tests_run++;
    if (p !== 30'h0 || lat !== 1 || nd !== 1) begin
      $display("FAIL zero_q: got product=%h lat=%0d done=%0d want 0 1 1", p, lat, nd);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    logic        tcs [4];
    logic [14:0] ms  [4];
    logic [14:0] qs  [4];
    logic [29:0] exp [3];
    logic [29:0] got [3];
    int          tdone [3];
    int          jobs, cyc, idx;
    tcs[0] = 1'b1; ms[0] = 15'd4;    qs[0] = 15'd5;    exp[0] = 30'd20;
    tcs[1] = 1'b1; ms[1] = 15'h7FFD; qs[1] = 15'd100;  exp[1] = 30'h3FFFFED4;
    tcs[2] = 1'b0; ms[2] = 15'd1000; qs[2] = 15'd1000; exp[2] = 30'h000F4240;
    tcs[3] = 1'b1; ms[3] = 15'h5555; qs[3] = 15'h2AAA;
    jobs = 0;
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      got[k] = 'x;
      tdone[k] = 0;
    end
    @(negedge clk);
    if15.start = 1'b1;
    if15.tc = tcs[0];
    if15.multiplicand = ms[0];
    if15.multiplier = qs[0];
    for (int i = 0; i < 60 && jobs < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (if15.done) begin
        got[jobs] = if15.product;
        tdone[jobs] = cyc;
        jobs++;
      end
      if (if15.busy) begin
        idx = if15.done ? jobs : jobs + 1;
        if (idx > 3) idx = 3;
        if15.tc = tcs[idx];
        if15.multiplicand = ms[idx];
        if15.multiplier = qs[idx];
      end
    end
    if15.start = 1'b0;
    tests_run++;
    if (jobs !== 3) begin
      $display("FAIL b2b_job_count: got %0d want 3", jobs);
      tests_failed++;
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (got[k] !== exp[k]) begin
        $display("FAIL b2b_product%0d: got %h want %h", k, got[k], exp[k]);
        tests_failed++;
      end
    end
    tests_run++;
    if (tdone[0] !== 7 || tdone[1] - tdone[0] !== 8 || tdone[2] - tdone[1] !== 8) begin
      $display("FAIL b2b_spacing: got %0d %0d %0d want 7 15 23", tdone[0], tdone[1], tdone[2]);
      tests_failed++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [29:0] p;
    int lat, nd, seen_done;
    @(negedge clk);
    if15.start = 1'b1;
    if15.tc = 1'b1;
    if15.multiplicand = 15'd4;
    if15.multiplier = 15'd5;
    @(negedge clk);
    if15.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (if15.busy !== 1'b0 || if15.done !== 1'b0 || if15.product !== 30'h0) begin
      $display("FAIL abort_clear: busy=%b done=%b product=%h want 0 0 0",
               if15.busy, if15.done, if15.product);
      tests_failed++;
    end
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (if15.done) seen_done++;
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (if15.done) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0 || if15.busy !== 1'b0) begin
      $display("FAIL abort_no_done: done_cycles=%0d busy=%b want 0 0", seen_done, if15.busy);
      tests_failed++;
    end
    run15(1'b1, 15'd6, 15'h7FFE, p, lat, nd);
    tests_run++;
    if (p !== 30'h3FFFFFF4 || lat !== 7 || nd !== 1) begin
      $display("FAIL abort_recover: got product=%h lat=%0d done=%0d want 3ffffff4 7 1",
               p, lat, nd);
      tests_failed++;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    if15.start = 1'b0;
    if15.tc = 1'b0;
    if15.multiplicand = '0;
    if15.multiplier = '0;
    if8.start = 1'b0;
    if8.tc = 1'b0;
    if8.multiplicand = '0;
    if8.multiplier = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_basic();
    test_signed();
    test_unsigned();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
